// File: rtl/zmc_pkg.sv
// Shared definitions for the zmc_master bank-switch initiator: window
// indices, per-window bank masks, responder power-up mapping and FSM states.
package zmc_pkg;

    localparam logic [1:0] WIN_F000 = 2'd0;
    localparam logic [1:0] WIN_E000 = 2'd1;
    localparam logic [1:0] WIN_C000 = 2'd2;
    localparam logic [1:0] WIN_8000 = 2'd3;

    localparam logic [7:0] MASK_W0 = 8'hFF;
    localparam logic [7:0] MASK_W1 = 8'h7F;
    localparam logic [7:0] MASK_W2 = 8'h3F;
    localparam logic [7:0] MASK_W3 = 8'h1F;

    localparam logic [7:0] SHADOW_RST_W0 = 8'h1E;
    localparam logic [7:0] SHADOW_RST_W1 = 8'h0E;
    localparam logic [7:0] SHADOW_RST_W2 = 8'h06;
    localparam logic [7:0] SHADOW_RST_W3 = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } zmc_state_e;

    // Bank bits implemented by each window; unused high bits are forced 0.
    function automatic logic [7:0] win_mask(input logic [1:0] win);
        case (win)
            WIN_F000: win_mask = MASK_W0;
            WIN_E000: win_mask = MASK_W1;
            WIN_C000: win_mask = MASK_W2;
            WIN_8000: win_mask = MASK_W3;
            default:  win_mask = MASK_W0;
        endcase
    endfunction

    // Responder power-up value of each window register.
    function automatic logic [7:0] shadow_rst(input logic [1:0] win);
        case (win)
            WIN_F000: shadow_rst = SHADOW_RST_W0;
            WIN_E000: shadow_rst = SHADOW_RST_W1;
            WIN_C000: shadow_rst = SHADOW_RST_W2;
            WIN_8000: shadow_rst = SHADOW_RST_W3;
            default:  shadow_rst = SHADOW_RST_W0;
        endcase
    endfunction

endpackage

// File: rtl/zmc_req_fifo.sv
// Request queue for zmc_master: synchronous FIFO with a first-word
// fall-through read port. Pushes while full and pops while empty are ignored.
module zmc_req_fifo
    import zmc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == (AW+1)'(DEPTH));
    assign empty  = (count_r == '0);
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign rdata  = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/zmc_master.sv
// Z80-side bank-switch initiator. Queues window/bank requests and replays
// each one as an address-setup / SDRD0-strobe / hold bus cycle, keeping a
// shadow copy of every window register for read-back.
module zmc_master
    import zmc_pkg::*;
#(
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 4,
    parameter int T_HOLD     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SKIP_SAME  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_WIN,
    input  logic [7:0] REQ_BANK,
    output logic [1:0] SDA_L,
    output logic [7:0] SDA_U,
    output logic       SDRD0,
    output logic       BUS_EN,
    output logic       BUSY,
    output logic [7:0] SHADOW0,
    output logic [7:0] SHADOW1,
    output logic [7:0] SHADOW2,
    output logic [7:0] SHADOW3
);

    localparam int T_MAX0 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX  = (T_MAX0 > T_HOLD) ? T_MAX0 : T_HOLD;
    localparam int PH_W   = $clog2(T_MAX + 1);

    zmc_state_e  state_r, state_nx;
    logic [PH_W-1:0] phase_r, phase_nx;
    logic [1:0]  sda_l_r, sda_l_nx;
    logic [7:0]  sda_u_r, sda_u_nx;
    logic        sdrd0_r, sdrd0_nx;
    logic        bus_en_r, bus_en_nx;
    logic [7:0]  shadow_r [4];

    logic        push_s;
    logic        pop_s;
    logic [9:0]  wdata_s;
    logic [9:0]  head_s;
    logic [1:0]  head_win_s;
    logic [7:0]  head_bank_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        skip_s;
    logic        shadow_we_s;

    // Masking happens on the way in so the queue only ever holds legal banks.
    assign push_s  = REQ_VALID & ~fifo_full_s;
    assign wdata_s = {REQ_WIN, REQ_BANK & win_mask(REQ_WIN)};

    zmc_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_win_s  = head_s[9:8];
    assign head_bank_s = head_s[7:0];
    assign skip_s      = (SKIP_SAME != 32'sd0) && (head_bank_s == shadow_r[head_win_s]);

    // The responder latches on the rising SDRD0 edge, i.e. the last strobe cycle.
    assign shadow_we_s = (state_r == ST_STROBE) && (phase_r == PH_W'(T_PULSE - 1));

    assign REQ_READY = ~fifo_full_s;
    assign BUSY      = ~fifo_empty_s | (state_r != ST_IDLE);
    assign SDA_L     = sda_l_r;
    assign SDA_U     = sda_u_r;
    assign SDRD0     = sdrd0_r;
    assign BUS_EN    = bus_en_r;
    assign SHADOW0   = shadow_r[0];
    assign SHADOW1   = shadow_r[1];
    assign SHADOW2   = shadow_r[2];
    assign SHADOW3   = shadow_r[3];

    // Next-state, phase timing and next bus-pin values.
    always_comb begin
        state_nx  = state_r;
        phase_nx  = phase_r + PH_W'(1);
        sda_l_nx  = sda_l_r;
        sda_u_nx  = sda_u_r;
        sdrd0_nx  = 1'b1;
        bus_en_nx = bus_en_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_nx  = '0;
                bus_en_nx = 1'b0;
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (skip_s) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx  = ST_SETUP;
                        sda_l_nx  = head_win_s;
                        sda_u_nx  = head_bank_s;
                        bus_en_nx = 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_r == PH_W'(T_SETUP - 1)) begin
                    state_nx = ST_STROBE;
                    phase_nx = '0;
                    sdrd0_nx = 1'b0;
                end else begin
                    sdrd0_nx = 1'b1;
                end
            end
            ST_STROBE: begin
                if (phase_r == PH_W'(T_PULSE - 1)) begin
                    state_nx = ST_HOLD;
                    phase_nx = '0;
                    sdrd0_nx = 1'b1;
                end else begin
                    sdrd0_nx = 1'b0;
                end
            end
            ST_HOLD: begin
                if (phase_r == PH_W'(T_HOLD - 1)) begin
                    state_nx  = ST_IDLE;
                    phase_nx  = '0;
                    bus_en_nx = 1'b0;
                    sda_l_nx  = 2'd0;
                    sda_u_nx  = 8'd0;
                end else begin
                    state_nx = ST_HOLD;
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                phase_nx  = '0;
                bus_en_nx = 1'b0;
                sda_l_nx  = 2'd0;
                sda_u_nx  = 8'd0;
            end
        endcase
    end

    // FSM and registered bus pins; reset drops SDRD0 high immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            phase_r  <= '0;
            sda_l_r  <= 2'd0;
            sda_u_r  <= 8'd0;
            sdrd0_r  <= 1'b1;
            bus_en_r <= 1'b0;
        end else begin
            state_r  <= state_nx;
            phase_r  <= phase_nx;
            sda_l_r  <= sda_l_nx;
            sda_u_r  <= sda_u_nx;
            sdrd0_r  <= sdrd0_nx;
            bus_en_r <= bus_en_nx;
        end
    end

    // Shadow window registers follow what the responder has latched.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= shadow_rst(2'(i));
            end
        end else if (shadow_we_s) begin
            shadow_r[sda_l_r] <= sda_u_r;
        end
    end

endmodule

// File: tb/tb_zmc_master.sv
// Self-checking bench for zmc_master: directed scenarios plus randomized
// request traffic checked against a queue-based transaction model.
module tb_zmc_master;

    localparam int T_SETUP = 2;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;
    localparam int DEPTH   = 4;
    localparam int PERIOD  = 1 + T_SETUP + T_PULSE + T_HOLD;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic [1:0] REQ_WIN = 2'd0;
    logic [7:0] REQ_BANK = 8'd0;
    logic       REQ_READY, SDRD0, BUS_EN, BUSY;
    logic [1:0] SDA_L;
    logic [7:0] SDA_U, SHADOW0, SHADOW1, SHADOW2, SHADOW3;

    // second instance with skipping disabled
    logic       ns_valid = 1'b0;
    logic [1:0] ns_win = 2'd0;
    logic [7:0] ns_bank = 8'd0;
    logic       ns_ready, ns_sdrd0, ns_bus_en, ns_busy;
    logic [1:0] ns_sda_l;
    logic [7:0] ns_sda_u, ns_sh0, ns_sh1, ns_sh2, ns_sh3;

    zmc_master #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
                 .FIFO_DEPTH(DEPTH), .SKIP_SAME(1)) u_dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WIN(REQ_WIN), .REQ_BANK(REQ_BANK), .SDA_L(SDA_L), .SDA_U(SDA_U),
        .SDRD0(SDRD0), .BUS_EN(BUS_EN), .BUSY(BUSY),
        .SHADOW0(SHADOW0), .SHADOW1(SHADOW1), .SHADOW2(SHADOW2), .SHADOW3(SHADOW3));

    zmc_master #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
                 .FIFO_DEPTH(DEPTH), .SKIP_SAME(0)) u_dut_ns (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(ns_valid), .REQ_READY(ns_ready),
        .REQ_WIN(ns_win), .REQ_BANK(ns_bank), .SDA_L(ns_sda_l), .SDA_U(ns_sda_u),
        .SDRD0(ns_sdrd0), .BUS_EN(ns_bus_en), .BUSY(ns_busy),
        .SHADOW0(ns_sh0), .SHADOW1(ns_sh1), .SHADOW2(ns_sh2), .SHADOW3(ns_sh3));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mshadow [4];
    logic [9:0] acc_q [$];      // accepted {win, raw bank}, in order
    int         fall_q [$];     // cycle numbers of SDRD0 falling edges
    int         cyc_n = 0;
    bit         in_cyc = 1'b0;
    int         setup_n, low_n, hold_n;
    logic [1:0] cur_w;
    logic [7:0] cur_b;

    function automatic logic [7:0] mask_of(input logic [1:0] w, input logic [7:0] b);
        logic [7:0] m;
        m = 8'hFF >> w;
        return b & m;
    endfunction

    function automatic logic [7:0] shadow_of(input logic [1:0] w);
        case (w)
            2'd0:    return SHADOW0;
            2'd1:    return SHADOW1;
            2'd2:    return SHADOW2;
            default: return SHADOW3;
        endcase
    endfunction

    task automatic reset_model();
        mshadow[0] = 8'h1E; mshadow[1] = 8'h0E; mshadow[2] = 8'h06; mshadow[3] = 8'h02;
        acc_q.delete();
    endtask

    // Requests equal to the current mapping retire silently.
    task automatic pop_skips();
        while (acc_q.size() > 0 &&
               mask_of(acc_q[0][9:8], acc_q[0][7:0]) == mshadow[acc_q[0][9:8]])
            void'(acc_q.pop_front());
    endtask

    // Bus monitor: checks each bus cycle against the next modelled command.
    always @(negedge CLK) begin
        logic [9:0] e;
        bit have;
        cyc_n++;
        if (RESET) begin
            in_cyc = 1'b0;
        end else if (BUS_EN) begin
            if (!in_cyc) begin
                in_cyc = 1'b1; setup_n = 0; low_n = 0; hold_n = 0;
                pop_skips();
                have = (acc_q.size() > 0);
                check_eq("cmd_avail", {31'd0, have}, 32'd1);
                if (have) begin
                    e = acc_q.pop_front();
                    cur_w = e[9:8];
                    cur_b = mask_of(e[9:8], e[7:0]);
                end else begin
                    cur_w = SDA_L;
                    cur_b = SDA_U;
                end
                check_eq("sda_l", {30'd0, SDA_L}, {30'd0, cur_w});
                check_eq("sda_u", {24'd0, SDA_U}, {24'd0, cur_b});
            end else begin
                check_eq("sda_stable", {22'd0, SDA_L, SDA_U}, {22'd0, cur_w, cur_b});
            end
            if (!SDRD0) begin
                low_n++;
                if (low_n == 1) fall_q.push_back(cyc_n);
            end else if (low_n == 0) begin
                setup_n++;
            end else begin
                hold_n++;
                if (hold_n == 1) check_eq("shadow_upd", {24'd0, shadow_of(cur_w)}, {24'd0, cur_b});
            end
        end else begin
            if (in_cyc) begin
                in_cyc = 1'b0;
                check_eq("setup_len", setup_n, T_SETUP);
                check_eq("pulse_len", low_n, T_PULSE);
                check_eq("hold_len", hold_n, T_HOLD);
                mshadow[cur_w] = cur_b;
            end
            check_eq("idle_bus", {21'd0, SDRD0, SDA_L, SDA_U}, {21'd0, 1'b1, 10'd0});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [1:0] w, input logic [7:0] b, output bit acc);
        @(negedge CLK);
        REQ_VALID = v; REQ_WIN = w; REQ_BANK = b;
        acc = v && REQ_READY;
        if (acc) acc_q.push_back({w, b});
    endtask

    task automatic check_shadows(input string tag);
        check_eq({tag, "_sh0"}, {24'd0, SHADOW0}, {24'd0, mshadow[0]});
        check_eq({tag, "_sh1"}, {24'd0, SHADOW1}, {24'd0, mshadow[1]});
        check_eq({tag, "_sh2"}, {24'd0, SHADOW2}, {24'd0, mshadow[2]});
        check_eq({tag, "_sh3"}, {24'd0, SHADOW3}, {24'd0, mshadow[3]});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        #1;
        check_eq("wait_idle", {31'd0, BUSY}, 32'd0);
        pop_skips();
        check_eq("q_drained", acc_q.size(), 0);
        check_shadows("idle");
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        REQ_VALID = 1'b0;
        ns_valid = 1'b0;
        repeat (2) @(negedge CLK);
        reset_model();
        RESET = 1'b0;
    endtask

    initial begin
        bit acc;
        int f0, busy_n, bus_n, lo_n, ns_busy_n, ns_bus_n, ns_lo_n, k;
        logic [7:0] b;

        // reset state
        reset_model();
        do_reset();
        #1;
        check_shadows("rst");
        check_eq("rst_sdrd0", {31'd0, SDRD0}, 32'd1);
        check_eq("rst_bus_en", {31'd0, BUS_EN}, 32'd0);
        check_eq("rst_ready", {31'd0, REQ_READY}, 32'd1);
        check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("rst_sda", {22'd0, SDA_L, SDA_U}, 32'd0);

        // single request, masked to 6 bits
        drive(1'b1, 2'd2, 8'hFF, acc);
        drive(1'b0, 2'd0, 8'h00, acc);
        wait_idle(100);
        check_eq("single_sh2", {24'd0, SHADOW2}, 32'h3F);

        // back-to-back burst until the queue fills
        f0 = fall_q.size();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'(i % 4), 8'h50 + 8'(i), acc);
            check_eq("b2b_acc", {31'd0, acc}, 32'd1);
        end
        drive(1'b1, 2'd0, 8'h99, acc);
        check_eq("b2b_full", {31'd0, REQ_READY}, 32'd0);
        check_eq("b2b_reject", {31'd0, acc}, 32'd0);
        drive(1'b0, 2'd0, 8'h00, acc);
        wait_idle(200);
        check_eq("b2b_count", fall_q.size() - f0, 5);
        for (int i = f0 + 1; i < fall_q.size(); i++)
            check_eq("b2b_spacing", fall_q[i] - fall_q[i-1], PERIOD);

        // bit 7 masked off for window 1
        drive(1'b1, 2'd1, 8'h80, acc);
        drive(1'b0, 2'd0, 8'h00, acc);
        wait_idle(100);
        check_eq("mask_sh1", {24'd0, SHADOW1}, 32'h00);

        // same-value request: skipped here, executed on the non-skipping copy
        do_reset();
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WIN = 2'd0; REQ_BANK = 8'h1E;
        ns_valid = 1'b1; ns_win = 2'd0; ns_bank = 8'h1E;
        acc_q.push_back({2'd0, 8'h1E});
        @(negedge CLK);
        REQ_VALID = 1'b0; ns_valid = 1'b0;
        busy_n = 0; bus_n = 0; lo_n = 0; ns_busy_n = 0; ns_bus_n = 0; ns_lo_n = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            busy_n += int'(BUSY); bus_n += int'(BUS_EN); lo_n += int'(!SDRD0);
            ns_busy_n += int'(ns_busy); ns_bus_n += int'(ns_bus_en); ns_lo_n += int'(!ns_sdrd0);
            @(negedge CLK);
        end
        check_eq("skip_busy", busy_n, 1);
        check_eq("skip_bus_en", bus_n, 0);
        check_eq("skip_strobe", lo_n, 0);
        check_eq("skip_sh0", {24'd0, SHADOW0}, 32'h1E);
        check_eq("noskip_busy", ns_busy_n, PERIOD);
        check_eq("noskip_bus_en", ns_bus_n, PERIOD - 1);
        check_eq("noskip_strobe", ns_lo_n, T_PULSE);
        check_eq("noskip_sh0", {24'd0, ns_sh0}, 32'h1E);
        wait_idle(50);

        // reset in the middle of a strobe
        drive(1'b1, 2'd3, 8'h11, acc);
        drive(1'b1, 2'd2, 8'h22, acc);
        drive(1'b1, 2'd1, 8'h33, acc);
        drive(1'b0, 2'd0, 8'h00, acc);
        k = 0;
        while (SDRD0 !== 1'b0 && k < 30) begin
            @(negedge CLK);
            k++;
        end
        check_eq("strobe_seen", {31'd0, SDRD0}, 32'd0);
        #2 RESET = 1'b1;
        #1;
        reset_model();
        check_eq("arst_sdrd0", {31'd0, SDRD0}, 32'd1);
        check_eq("arst_bus_en", {31'd0, BUS_EN}, 32'd0);
        check_eq("arst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("arst_ready", {31'd0, REQ_READY}, 32'd1);
        check_shadows("arst");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        drive(1'b1, 2'd3, 8'hFF, acc);
        drive(1'b0, 2'd0, 8'h00, acc);
        wait_idle(100);
        check_eq("post_rst_sh3", {24'd0, SHADOW3}, 32'h1F);

        // randomized traffic; small bank pool makes same-value skips frequent
        for (int i = 0; i < 120; i++) begin
            b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), b, acc);
        end
        drive(1'b0, 2'd0, 8'h00, acc);
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
